// File: rtl/main_memory_if.sv
// CPU-side memory bus plus the streaming program-loader port of main_memory.
// master = CPU/loader side, slave = the memory.
interface main_memory_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              cpu_hold;
  logic              boot_done;
  logic              mem_err;
  logic [15:0]       wr_count;

  modport master (
    output addr, rd, wr, wdata, load_valid, load_data, load_last,
    input  rdata, load_ready, cpu_hold, boot_done, mem_err, wr_count
  );

  modport slave (
    input  addr, rd, wr, wdata, load_valid, load_data, load_last,
    output rdata, load_ready, cpu_hold, boot_done, mem_err, wr_count
  );
endinterface

// File: rtl/main_memory.sv
// Unified program/data RAM: optional zero-fill after reset, program load over
// a streaming port while the CPU is held, then combinational-read CPU service.
module main_memory #(
  parameter int ADDR_W         = 11,
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 2048,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic          i_clock,
  input logic          i_reset_n,
  main_memory_if.slave bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_BOOT  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]  DEPTH_A  = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [1:0]        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic              r_mem_err;
  logic [15:0]       r_wr_count;

  logic              w_run;
  logic              w_in_range;
  logic [PTR_W-1:0]  w_idx;
  logic              w_rd_ok;
  logic              w_cpu_wr;
  logic              w_load_acc;
  logic              w_ptr_last;
  logic              w_we;
  logic [PTR_W-1:0]  w_waddr;
  logic [DATA_W-1:0] w_wdata;

  assign w_run      = (r_state == S_RUN);
  assign w_in_range = ({1'b0, bus.addr} < DEPTH_A);
  assign w_idx      = bus.addr[PTR_W-1:0];
  assign w_rd_ok    = w_run & bus.rd & ~bus.wr & w_in_range;
  assign w_cpu_wr   = w_run & bus.wr & ~bus.rd & w_in_range;
  assign w_load_acc = (r_state == S_BOOT) & bus.load_valid;
  assign w_ptr_last = (r_ptr == PTR_LAST);

  // Single write port shared by zero-fill, loader and CPU; the state picks the source.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_ptr;
    w_wdata = '0;
    case (r_state)
      S_CLEAR: w_we = 1'b1;
      S_BOOT: begin
        w_we    = w_load_acc;
        w_wdata = bus.load_data;
      end
      S_RUN: begin
        w_we    = w_cpu_wr;
        w_waddr = w_idx;
        w_wdata = bus.wdata;
      end
      default: w_we = 1'b0;
    endcase
  end

  // Reset aborts activity but never writes the array itself.
  always_ff @(posedge i_clock) begin
    if (i_reset_n && w_we) r_mem[w_waddr] <= w_wdata;
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state    <= CLEAR_ON_RESET ? S_CLEAR : S_BOOT;
      r_ptr      <= '0;
      r_mem_err  <= 1'b0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (w_ptr_last) begin
            r_ptr   <= '0;
            r_state <= S_BOOT;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        S_BOOT: begin
          if (w_load_acc) begin
            if (bus.load_last || w_ptr_last) begin
              r_ptr   <= '0;
              r_state <= S_RUN;
              // Image filled the array without a terminating word.
              if (!bus.load_last) r_mem_err <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end
        end
        S_RUN: begin
          if ((bus.rd && bus.wr) || ((bus.rd || bus.wr) && !w_in_range))
            r_mem_err <= 1'b1;
          if (w_cpu_wr && (r_wr_count != 16'hFFFF))
            r_wr_count <= r_wr_count + 16'd1;
        end
        default: begin
          r_state <= S_BOOT;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  assign bus.rdata      = w_rd_ok ? r_mem[w_idx] : '0;
  assign bus.load_ready = (r_state == S_BOOT);
  assign bus.cpu_hold   = ~w_run;
  assign bus.boot_done  = w_run;
  assign bus.mem_err    = r_mem_err;
  assign bus.wr_count   = r_wr_count;
endmodule
